// File: rtl/weight_load_ctrl.sv
// Weight-row loader: reads NUM_PE consecutive SRAM words from base_addr and strobes one PE load enable per word.
// Optional WGT_LOAD_STALL_EN adds mem_gnt; a read issues only in granted cycles.
module weight_load_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_PE     = 9,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
`ifdef WGT_LOAD_STALL_EN
   input  logic                  mem_gnt,
`endif
   output logic [DATA_WIDTH-1:0] wgt_data,
   output logic [NUM_PE-1:0]     set_wgt,
   output logic                  busy,
   output logic                  done
);

   localparam int CNT_W = $clog2(NUM_PE);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PE - 1);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [CNT_W-1:0]      cnt_inc;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  rd_q, rd_d;
   logic [NUM_PE-1:0]     set_wgt_q, set_wgt_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  gnt;

`ifdef WGT_LOAD_STALL_EN
   assign gnt = mem_gnt;
`else
   assign gnt = 1'b1;
`endif

   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      base_d    = base_q;
      addr_d    = addr_q;
      rd_d      = rd_q;
      busy_d    = busy_q;
      set_wgt_d = '0;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_READ;
               base_d  = base_addr;
               addr_d  = base_addr;
               cnt_d   = '0;
               rd_d    = 1'b1;
               busy_d  = 1'b1;
            end
         end
         S_READ: begin
            // rd_q is the pending request; it only counts as a read when granted
            if (rd_q && gnt) begin
               set_wgt_d = NUM_PE'(1) << cnt_q;
               if (cnt_q == LAST) begin
                  rd_d    = 1'b0;
                  state_d = S_DRAIN;
               end else begin
                  cnt_d  = cnt_inc;
                  addr_d = base_q + ADDR_WIDTH'(cnt_inc);
               end
            end
         end
         S_DRAIN: begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         base_q    <= '0;
         addr_q    <= '0;
         rd_q      <= 1'b0;
         set_wgt_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         base_q    <= base_d;
         addr_q    <= addr_d;
         rd_q      <= rd_d;
         set_wgt_q <= set_wgt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign mem_rd_en = rd_q & gnt;
   assign mem_addr  = addr_q;
   assign wgt_data  = mem_rdata;
   assign set_wgt   = set_wgt_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Bench for weight_load_ctrl: SRAM + PE register model, per-cycle expectations derived from read issue order.
module tb_weight_load_ctrl;

   localparam int DW  = 8;
   localparam int NPE = 9;
   localparam int AW  = 10;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [AW-1:0]  base_addr = '0;
   logic           mem_rd_en;
   logic [AW-1:0]  mem_addr;
   logic [DW-1:0]  mem_rdata = '0;
   logic           mem_gnt = 1'b1;
   logic [DW-1:0]  wgt_data;
   logic [NPE-1:0] set_wgt;
   logic           busy;
   logic           done;

   logic [DW-1:0]  sram [1 << AW];
   int checks = 0;
   int errors = 0;

   weight_load_ctrl #(.DATA_WIDTH(DW), .NUM_PE(NPE), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
`ifdef WGT_LOAD_STALL_EN
      .mem_gnt(mem_gnt),
`endif
      .wgt_data(wgt_data), .set_wgt(set_wgt), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // SRAM: one-cycle read latency
   always @(posedge clk) if (mem_rd_en) mem_rdata <= sram[mem_addr];

   task automatic fill_random();
      for (int i = 0; i < (1 << AW); i++) sram[i] = DW'($urandom);
   endtask

   // One load from base; p1/p2 are cycles in which an extra start pulse is driven.
   task automatic do_load(input logic [AW-1:0] base, input int p1, input int p2, input bit stall);
      int issued = 0;
      int last_rd = -1;
      int prev_idx = -1;
      int done_cnt = 0;
      bit g_cur;
      logic [AW-1:0]  exp_addr;
      logic [NPE-1:0] exp_set;
      logic           exp_rd, exp_done, exp_busy;
      logic [DW-1:0]  pe_cap [NPE];
      for (int i = 0; i < NPE; i++) pe_cap[i] = 'x;
      @(negedge clk);
      start = 1'b1;
      base_addr = base;
      g_cur = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      mem_gnt = g_cur;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         exp_rd   = (issued < NPE) && g_cur;
         exp_addr = AW'(int'(base) + issued);
         exp_set  = (prev_idx >= 0) ? (NPE'(1) << prev_idx) : '0;
         exp_done = (last_rd >= 0) && (c == last_rd + 2);
         exp_busy = (last_rd < 0) || (c <= last_rd + 1);
         checks++;
         if (mem_rd_en !== exp_rd) begin
            errors++;
            $display("FAIL rd_en cycle %0d: got %b want %b", c, mem_rd_en, exp_rd);
         end
         if (exp_rd) begin
            checks++;
            if (mem_addr !== exp_addr) begin
               errors++;
               $display("FAIL addr cycle %0d: got %h want %h", c, mem_addr, exp_addr);
            end
         end
         checks++;
         if (set_wgt !== exp_set) begin
            errors++;
            $display("FAIL set_wgt cycle %0d: got %b want %b", c, set_wgt, exp_set);
         end
         checks++;
         if (done !== exp_done || busy !== exp_busy) begin
            errors++;
            $display("FAIL done/busy cycle %0d: got %b/%b want %b/%b", c, done, busy, exp_done, exp_busy);
         end
         for (int i = 0; i < NPE; i++) if (set_wgt[i]) pe_cap[i] = wgt_data;
         if (done === 1'b1) done_cnt++;
         prev_idx = exp_rd ? issued : -1;
         if (exp_rd) begin
            issued++;
            if (issued == NPE) last_rd = c;
         end
         start = ((c + 1) == p1) || ((c + 1) == p2);
         base_addr = AW'($urandom);
         g_cur = (stall && c < 100) ? 1'($urandom_range(0, 1)) : 1'b1;
         mem_gnt = g_cur;
         if (last_rd >= 0 && c >= last_rd + 4) break;
      end
      start = 1'b0;
      mem_gnt = 1'b1;
      checks++;
      if (done_cnt !== 1 || issued !== NPE) begin
         errors++;
         $display("FAIL load_done_count: got %0d done, %0d reads; want 1, %0d", done_cnt, issued, NPE);
      end
      for (int i = 0; i < NPE; i++) begin
         checks++;
         if (pe_cap[i] !== sram[AW'(int'(base) + i)]) begin
            errors++;
            $display("FAIL pe_value[%0d]: got %h want %h", i, pe_cap[i], sram[AW'(int'(base) + i)]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if ({mem_rd_en, mem_addr, set_wgt, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%b addr=%h set=%b busy=%b done=%b want all 0",
                     mem_rd_en, mem_addr, set_wgt, busy, done);
         end
      end
      start = 1'b0;
      rst_n = 1'b1;
      do_load(AW'(10'h2A5), -1, -1, 1'b0);
   endtask

   task automatic test_basic();
      fill_random();
      for (int i = 0; i < NPE; i++) sram[16 + i] = DW'(i + 1);
      do_load(AW'(10'h010), -1, -1, 1'b0);
   endtask

   task automatic test_wrap();
      fill_random();
      do_load(AW'(10'h3FC), -1, -1, 1'b0);
   endtask

   task automatic test_ignored_start();
      fill_random();
      do_load(AW'($urandom), 4, NPE + 2, 1'b0);
   endtask

   task automatic test_back_to_back();
      int dn = 0;
      int rds = 0;
      int first2 = -1;
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 2 * NPE + 5; c++) begin
         @(negedge clk);
         if (done === 1'b1) dn++;
         if (mem_rd_en === 1'b1) begin
            rds++;
            if (c > NPE + 2 && first2 < 0) first2 = c;
         end
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (dn !== 2 || rds !== 2 * NPE) begin
         errors++;
         $display("FAIL b2b_counts: got %0d done %0d reads want 2 and %0d", dn, rds, 2 * NPE);
      end
      checks++;
      if (first2 !== NPE + 4) begin
         errors++;
         $display("FAIL b2b_restart: second load first read cycle %0d want %0d", first2, NPE + 4);
      end
   endtask

   task automatic test_abort();
      int dn = 0;
      @(negedge clk);
      start = 1'b1;
      base_addr = AW'($urandom);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({mem_rd_en, set_wgt, busy, done} !== '0 || mem_addr !== '0) begin
         errors++;
         $display("FAIL abort_async: got rd=%b addr=%h set=%b busy=%b done=%b want all 0",
                  mem_rd_en, mem_addr, set_wgt, busy, done);
      end
      repeat (3) begin
         @(negedge clk);
         if (done === 1'b1 || mem_rd_en === 1'b1) dn++;
      end
      rst_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1 || mem_rd_en === 1'b1) dn++;
      end
      checks++;
      if (dn !== 0) begin
         errors++;
         $display("FAIL abort_quiet: got %0d active cycles want 0", dn);
      end
      fill_random();
      do_load(AW'($urandom), -1, -1, 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 4; n++) begin
         fill_random();
         do_load(AW'($urandom), -1, -1, 1'b0);
      end
   endtask

`ifdef WGT_LOAD_STALL_EN
   task automatic test_stall();
      for (int n = 0; n < 4; n++) begin
         fill_random();
         do_load(AW'($urandom), -1, -1, 1'b1);
      end
   endtask
`endif

   initial begin
      fill_random();
      test_reset();
      test_basic();
      test_wrap();
      test_ignored_start();
      test_back_to_back();
      test_abort();
      test_random();
`ifdef WGT_LOAD_STALL_EN
      test_stall();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
